// File: rtl/bus_decode_pkg.sv
// Shared types and constants for the bus region decoder.
// Holds the FSM state encoding, region entry layout and reset table.
// Default parameter values live here so every file agrees on them.
package bus_decode_pkg;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_NUM_REGIONS = 4;
  localparam int DEF_WS_W        = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERROR  = 2'd2
  } state_t;

  // One region table entry at the default widths.
  typedef struct packed {
    logic                  en;
    logic [DEF_ADDR_W-1:0] base;
    logic [DEF_ADDR_W-1:0] mask;
    logic [DEF_WS_W-1:0]   ws;
  } region_t;

  // Reset table: lower half of the address space is memory, upper half is I/O.
  // Only the address MSB is significant in base/mask, so these scale to any ADDR_W.
  localparam region_t RESET_ENTRY0 = '{en: 1'b1, base: 16'h0000, mask: 16'h8000, ws: 4'd0};
  localparam region_t RESET_ENTRY1 = '{en: 1'b1, base: 16'h8000, mask: 16'h8000, ws: 4'd0};

endpackage

// File: rtl/region_match.sv
// Single region comparator: masked address compare gated by the entry enable.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle against the live request address.
module region_match #(
  parameter int ADDR_W = 16
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] mask,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit
);

  // A zero mask makes the compare trivially true, so such an entry matches everything.
  assign hit = en && ((addr & mask) == (base & mask));

endmodule

// File: rtl/bus_region_decoder.sv
// Programmable address decoder: one-hot region select with per-region wait states.
// Latency: sel/ack from T+1; hit holds sel for ws+1 cycles, miss acks with err on T+1.
// Backpressure: req_ready is high only in IDLE; requests are taken one at a time.
module bus_region_decoder
  import bus_decode_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_REGIONS = DEF_NUM_REGIONS,
  parameter int WS_W        = DEF_WS_W,
  parameter int IDX_W       = $clog2(NUM_REGIONS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [ADDR_W-1:0]      req_addr,
  output logic                   req_ready,
  output logic [NUM_REGIONS-1:0] sel,
  output logic                   ack,
  output logic                   err,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic                   cfg_en,
  input  logic [ADDR_W-1:0]      cfg_base,
  input  logic [ADDR_W-1:0]      cfg_mask,
  input  logic [WS_W-1:0]        cfg_ws
);

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] mask;
    logic [WS_W-1:0]   ws;
  } entry_t;

  // Map the package reset entries onto this instance's widths (only the MSB matters).
  function automatic entry_t reset_entry(input int i);
    entry_t e;
    e = '0;
    if (i == 0) begin
      e.en               = RESET_ENTRY0.en;
      e.base[ADDR_W-1]   = RESET_ENTRY0.base[DEF_ADDR_W-1];
      e.mask[ADDR_W-1]   = RESET_ENTRY0.mask[DEF_ADDR_W-1];
      e.ws               = WS_W'(RESET_ENTRY0.ws);
    end else if (i == 1) begin
      e.en               = RESET_ENTRY1.en;
      e.base[ADDR_W-1]   = RESET_ENTRY1.base[DEF_ADDR_W-1];
      e.mask[ADDR_W-1]   = RESET_ENTRY1.mask[DEF_ADDR_W-1];
      e.ws               = WS_W'(RESET_ENTRY1.ws);
    end
    return e;
  endfunction

  entry_t                 tbl [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] hit_vec;
  logic                   any_hit;
  logic [IDX_W-1:0]       win_idx;
  logic [NUM_REGIONS-1:0] win_sel;
  logic [WS_W-1:0]        win_ws;
  logic                   cfg_ok;
  state_t                 state;
  logic [WS_W-1:0]        cnt_q;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
    region_match #(.ADDR_W(ADDR_W)) u_match (
      .en   (tbl[g].en),
      .base (tbl[g].base),
      .mask (tbl[g].mask),
      .addr (req_addr),
      .hit  (hit_vec[g])
    );
  end

  // Priority encode: scan from the top so the lowest matching index wins.
  always_comb begin
    any_hit = |hit_vec;
    win_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit_vec[i]) win_idx = IDX_W'(i);
    end
    win_sel          = '0;
    win_sel[win_idx] = any_hit;
    win_ws           = tbl[win_idx].ws;
  end

  // Out-of-range indices are dropped rather than aliasing onto a real entry.
  assign cfg_ok = cfg_we && (32'(cfg_idx) < 32'(NUM_REGIONS));

  // Region table: reloads on reset; a write lands at the edge, after any same-cycle decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGIONS; i++) tbl[i] <= reset_entry(i);
    end else if (cfg_ok) begin
      tbl[cfg_idx] <= '{en: cfg_en, base: cfg_base, mask: cfg_mask, ws: cfg_ws};
    end
  end

  // Request FSM with registered outputs; ACCESS runs on its latched select and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt_q     <= '0;
      req_ready <= 1'b1;
      sel       <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (any_hit) begin
              state <= ACCESS;
              cnt_q <= win_ws;
              sel   <= win_sel;
              ack   <= (win_ws == '0);
            end else begin
              state <= ERROR;
              ack   <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
            ack   <= (cnt_q == WS_W'(1));
          end else begin
            state     <= IDLE;
            sel       <= '0;
            ack       <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        ERROR: begin
          state     <= IDLE;
          ack       <= 1'b0;
          err       <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          sel       <= '0;
          ack       <= 1'b0;
          err       <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
